// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle layout and selector encoding for pipe_stage_reg
// and its sub-modules.
package pipe_pkg;

  // Bundle layout, MSB first: write-back, memory, execute fields.
  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] mem;
    logic [2:0] ex;
  } ctrl_bundle_t;

  localparam int unsigned CTRL_W = $bits(ctrl_bundle_t);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 3;
  localparam int unsigned TAG_W  = 15;
  localparam int unsigned CNT_W  = 16;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    M_HOLD,
    M_FROM_SKID,
    M_FROM_IN,
    M_DRAIN
  } m_sel_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle of one pipeline stage register: the stage itself
// uses the slave view, the surrounding pipeline uses the master view.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned LANES  = pipe_pkg::LANES,
  parameter int unsigned TAG_W  = pipe_pkg::TAG_W,
  parameter int unsigned CNT_W  = pipe_pkg::CNT_W
);

  logic                    valid_i;
  logic                    ready_o;
  logic [CTRL_W-1:0]       ctrl_i;
  logic [LANES*DATA_W-1:0] data_i;
  logic [TAG_W-1:0]        tag_i;
  logic                    flush_i;
  logic                    valid_o;
  logic                    ready_i;
  logic [CTRL_W-1:0]       ctrl_o;
  logic [LANES*DATA_W-1:0] data_o;
  logic [TAG_W-1:0]        tag_o;
  logic [CNT_W-1:0]        stall_cnt_o;

  modport slave (
    input  valid_i, ctrl_i, data_i, tag_i, flush_i, ready_i,
    output ready_o, valid_o, ctrl_o, data_o, tag_o, stall_cnt_o
  );

  modport master (
    output valid_i, ctrl_i, data_i, tag_i, flush_i, ready_i,
    input  ready_o, valid_o, ctrl_o, data_o, tag_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_slot.sv
// One pipeline entry (valid, control bundle, data lanes, tag) updated on the
// falling clock edge; clear_i empties the entry and zeroes its control.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned LANES  = pipe_pkg::LANES,
  parameter int unsigned TAG_W  = pipe_pkg::TAG_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic                    clear_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic [LANES*DATA_W-1:0] data_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    valid_o,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [LANES*DATA_W-1:0] data_o,
  output logic [TAG_W-1:0]        tag_o
);

  localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

  logic                    valid_q, valid_d;
  logic [CTRL_W-1:0]       ctrl_q, ctrl_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]        tag_q, tag_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = NOP;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
      tag_d   = tag_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= NOP;
      // NOTE: data and tag are reset too, so outputs read all-zero straight after reset.
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready flow control, flush, bubble
// masking and a saturating stall counter. Define PIPE_STAGE_SKID_EN for the skid slot.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned LANES  = pipe_pkg::LANES,
  parameter int unsigned TAG_W  = pipe_pkg::TAG_W,
  parameter int unsigned CNT_W  = pipe_pkg::CNT_W
) (
  input logic             clk_i,
  input logic             rst_i,
  pipe_stage_reg_if.slave bus
);

  localparam int unsigned       DW      = LANES * DATA_W;
  localparam logic [CTRL_W-1:0] NOP     = CTRL_W'(CTRL_NOP);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_src;
  logic [DW-1:0]     m_data, s_data, m_data_src;
  logic [TAG_W-1:0]  m_tag, s_tag, m_tag_src;

  logic   ready, in_fire, out_fire, m_free;
  logic   m_load, m_clear;
  m_sel_e m_sel;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign in_fire  = bus.valid_i & ready;
  assign out_fire = m_valid & bus.ready_i;
  assign m_free   = ~m_valid | out_fire;

  // The skid entry is older than anything on the input, so it refills M first.
  always_comb begin
    m_sel = M_HOLD;
    if (m_free) begin
      if (s_valid)      m_sel = M_FROM_SKID;
      else if (in_fire) m_sel = M_FROM_IN;
      else              m_sel = M_DRAIN;
    end
  end

  assign m_load     = (m_sel == M_FROM_SKID) | (m_sel == M_FROM_IN);
  assign m_clear    = bus.flush_i | (m_sel == M_DRAIN);
  assign m_ctrl_src = (m_sel == M_FROM_SKID) ? s_ctrl : bus.ctrl_i;
  assign m_data_src = (m_sel == M_FROM_SKID) ? s_data : bus.data_i;
  assign m_tag_src  = (m_sel == M_FROM_SKID) ? s_tag  : bus.tag_i;

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .LANES (LANES),
    .TAG_W (TAG_W)
  ) u_main (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (m_load),
    .clear_i(m_clear),
    .ctrl_i (m_ctrl_src),
    .data_i (m_data_src),
    .tag_i  (m_tag_src),
    .valid_o(m_valid),
    .ctrl_o (m_ctrl),
    .data_o (m_data),
    .tag_o  (m_tag)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic s_load, s_clear;

  // S catches the input only while M is stuck; ready_o then drops one edge later.
  assign s_load  = m_valid & ~out_fire & in_fire;
  assign s_clear = bus.flush_i | (m_sel == M_FROM_SKID);

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .LANES (LANES),
    .TAG_W (TAG_W)
  ) u_skid (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (s_load),
    .clear_i(s_clear),
    .ctrl_i (bus.ctrl_i),
    .data_i (bus.data_i),
    .tag_i  (bus.tag_i),
    .valid_o(s_valid),
    .ctrl_o (s_ctrl),
    .data_o (s_data),
    .tag_o  (s_tag)
  );

  assign ready = ~s_valid;
`else
  assign s_valid = 1'b0;
  assign s_ctrl  = NOP;
  assign s_data  = '0;
  assign s_tag   = '0;
  assign ready   = bus.ready_i | ~m_valid;
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !bus.ready_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign bus.ready_o     = ready;
  assign bus.valid_o     = m_valid;
  assign bus.ctrl_o      = m_valid ? m_ctrl : NOP;
  assign bus.data_o      = m_data;
  assign bus.tag_o       = m_tag;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule
